// File: rtl/imem_boot_loader.sv
// imem_boot_loader: instruction store with a byte-stream boot loader.
// A load is a 4-byte big-endian word count N followed by N big-endian
// 32-bit words. The processor is held in reset until the load completes.
// After that, fetches return mem[pc] one clock after pc is sampled.
//
// rx handshake: a byte moves on a rising edge only when rx_valid and
// rx_ready are both high. rx_ready depends only on the state register,
// never on rx_valid. If load_req arrives on the same edge as a byte,
// load_req wins and the byte is dropped.
module imem_boot_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instruction,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        load_req,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        load_error,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HEADER = 2'd1;
   localparam logic [1:0] LOAD   = 2'd2;
   localparam logic [1:0] RUN    = 2'd3;

   localparam logic [AW:0] ADDR_ONE = {{AW{1'b0}}, 1'b1};

   logic [1:0]  state;
   logic [1:0]  byte_idx;
   logic [AW:0] addr;
   logic [AW:0] n_words;
   logic [23:0] shift;
   logic        err_q;

   logic [31:0] mem [DEPTH];

   logic        xfer;
   logic        last_byte;
   logic [31:0] full_word;
   logic [AW:0] addr_nxt;
   logic        pc_in_range;

   assign xfer        = rx_valid && rx_ready && !load_req;
   assign last_byte   = xfer && (byte_idx == 2'd3);
   assign full_word   = {shift, rx_data};
   assign addr_nxt    = addr + ADDR_ONE;
   assign pc_in_range = (pc < 32'(DEPTH));

   // Outputs decoded straight from the state register.
   assign rx_ready   = (state == HEADER) || (state == LOAD);
   assign cpu_reset  = (state != RUN);
   assign load_done  = (state == RUN);
   assign load_error = err_q;
   assign fsm_state  = state;

   // Loader FSM: header collection, word assembly, address counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         byte_idx <= 2'd0;
         addr     <= '0;
         n_words  <= '0;
         shift    <= '0;
         err_q    <= 1'b0;
      end else if (load_req) begin
         state    <= HEADER;
         byte_idx <= 2'd0;
         addr     <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            HEADER: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  shift    <= {shift[15:0], rx_data};
                  if (last_byte) begin
                     if (full_word == 32'd0) begin
                        state <= RUN;
                     end else if (full_word > 32'(DEPTH)) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                     end else begin
                        n_words <= full_word[AW:0];
                        addr    <= '0;
                        state   <= LOAD;
                     end
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  shift    <= {shift[15:0], rx_data};
                  if (last_byte) begin
                     addr <= addr_nxt;
                     if (addr_nxt == n_words) begin
                        state <= RUN;
                     end
                  end
               end
            end
            default: begin
               // IDLE and RUN wait for load_req, handled above.
            end
         endcase
      end
   end

   // Instruction store write port; memory is never cleared.
   always_ff @(posedge clk) begin
      if ((state == LOAD) && last_byte) begin
         mem[addr[AW-1:0]] <= full_word;
      end
   end

   // Registered fetch: zero outside RUN, on a reload request, or out of range.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction <= 32'd0;
      end else if ((state == RUN) && !load_req && pc_in_range) begin
         instruction <= mem[pc[AW-1:0]];
      end else begin
         instruction <= 32'd0;
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: byte-stream loads, fetch scoreboard,
// reload and abort, oversize header, and async reset in the middle of a load.
module tb_imem_boot_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        load_req;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;
   logic [1:0]  fsm_state;

   int n_checks;
   int n_fail;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] prog_q[$];
   logic [31:0] exp_q[$];

   imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset      (rst),
      .pc         (pc),
      .instruction(instruction),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .load_req   (load_req),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error),
      .fsm_state  (fsm_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one byte; inputs change on negedge, so the transfer occurs on the
   // following posedge once rx_ready is high. Returns on a negedge.
   task automatic send_byte(input logic [7:0] b, input bit stall);
      int cnt;
      if (stall) begin
         while ($urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      cnt = 0;
      while (!rx_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit stall);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], stall);
   endtask

   task automatic pulse_load_req();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   // Load prog_q after load_req; checks completion timing, updates the model.
   task automatic load_prog(input bit stall);
      pulse_load_req();
      send_word(32'(prog_q.size()), stall);
      for (int w = 0; w < prog_q.size(); w++) begin
         for (int i = 3; i >= 0; i--) begin
            if (w == prog_q.size() - 1 && i == 0)
               check("cpu_reset_before_last", {31'd0, cpu_reset}, 32'd1);
            send_byte(prog_q[w][8*i +: 8], stall);
         end
         model_mem[w] = prog_q[w];
      end
      check("cpu_reset_after_load", {31'd0, cpu_reset}, 32'd0);
      check("load_done_after_load", {31'd0, load_done}, 32'd1);
   endtask

   // Scoreboard: push expectation when pc is driven, pop one cycle later.
   task automatic fetch(input logic [31:0] addr);
      logic [31:0] e;
      pc = addr;
      exp_q.push_back((addr < DEPTH) ? model_mem[addr[AW-1:0]] : 32'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("fetch_pc_%0h", addr), instruction, e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"},     instruction,             32'd0);
      check({tag, "_rx_ready"},  {31'd0, rx_ready},       32'd0);
      check({tag, "_cpu_reset"}, {31'd0, cpu_reset},      32'd1);
      check({tag, "_load_done"}, {31'd0, load_done},      32'd0);
      check({tag, "_load_err"},  {31'd0, load_error},     32'd0);
      check({tag, "_state"},     {30'd0, fsm_state},      32'd0);
   endtask

   task automatic basic_prog();
      prog_q.delete();
      prog_q.push_back(32'h12345678);
      prog_q.push_back(32'h9ABCDEF0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      pc       = 32'd0;
      rx_data  = 8'd0;
      rx_valid = 1'b0;
      load_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Basic load
      basic_prog();
      load_prog(1'b0);
      fetch(32'd0);
      fetch(32'd1);

      // Full-depth load with random words (N == DEPTH boundary)
      prog_q.delete();
      for (int i = 0; i < DEPTH; i++) prog_q.push_back($urandom);
      load_prog(1'b0);
      fetch(32'(DEPTH - 1));
      for (int i = 0; i < 6; i++) fetch(32'($urandom_range(0, DEPTH - 1)));

      // rx_valid held in RUN is ignored
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("run_hold_state", {30'd0, fsm_state}, 32'd3);
      end
      rx_valid = 1'b0;

      // Stalled stream gives the same contents
      basic_prog();
      load_prog(1'b1);
      fetch(32'd0);
      fetch(32'd1);
      fetch(32'd2);

      // Out-of-range fetches
      fetch(32'(DEPTH));
      fetch(32'h8000_0000);
      fetch(32'(DEPTH - 1));

      // Reload from RUN
      pc = 32'd0;
      pulse_load_req();
      check("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("reload_load_done", {31'd0, load_done}, 32'd0);
      check("reload_instr",     instruction,        32'd0);
      check("reload_state",     {30'd0, fsm_state}, 32'd1);
      // load_req coinciding with a byte drops the byte
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      pulse_load_req();
      rx_valid = 1'b0;
      // abort in the middle of LOAD, then a clean N=1 load
      send_word(32'd2, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      check("mid_load_state", {30'd0, fsm_state}, 32'd2);
      check("mid_load_err",   {31'd0, load_error}, 32'd0);
      prog_q.delete();
      prog_q.push_back(32'hCAFEF00D);
      load_prog(1'b0);
      fetch(32'd0);
      fetch(32'd1);
      check("old_word_kept", model_mem[1], 32'h9ABCDEF0);

      // Oversize header
      pulse_load_req();
      send_word(32'(DEPTH + 1), 1'b0);
      check("oversize_err",       {31'd0, load_error}, 32'd1);
      check("oversize_state",     {30'd0, fsm_state},  32'd0);
      check("oversize_cpu_reset", {31'd0, cpu_reset},  32'd1);
      rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle_hold_state", {30'd0, fsm_state}, 32'd0);
      end
      rx_valid = 1'b0;
      pulse_load_req();
      check("err_cleared", {31'd0, load_error}, 32'd0);

      // Async reset after 6 bytes, between edges
      send_word(32'd2, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      @(negedge clk);
      rst = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_reset_no_run", {31'd0, cpu_reset}, 32'd1);
      end
      rx_valid = 1'b0;
      prog_q.delete();
      prog_q.push_back(32'h0BADBEEF);
      prog_q.push_back(32'h13579BDF);
      load_prog(1'b1);
      fetch(32'd1);
      fetch(32'd0);
      fetch(32'd2);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Instruction-memory responder with a byte-stream boot loader. It receives a program as a byte stream over a valid/ready handshake and writes it into an internal word-addressed instruction store. While loading, it holds the processor in reset. Once loaded, it answers the processor's fetches: the word at `pc` is returned on `instruction` one clock later. It sits between the host/download path and the `processor` fetch port, and replaces the behavioural memory array.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit instruction words. Must be ≤ 65536.
- `AW`, default 6: address bits, equal to clog2(DEPTH).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high. Forces every state register and output to its reset value immediately.
- `pc`, in, 32: word index of the processor's fetch (not a byte address).
- `instruction`, out, 32: fetched word, registered.
- `rx_data`, in, 8: incoming load byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader can accept a byte this cycle.
- `load_req`, in, 1: one-cycle pulse that starts a (re)load.
- `cpu_reset`, out, 1: reset to `processor`. High except in RUN.
- `load_done`, out, 1: high while in RUN.
- `load_error`, out, 1: sticky error flag. Cleared by `reset` or by an accepted `load_req`.

## Operation
States:
- **IDLE**
  - `rx_ready`=0.
  - `load_req` → HEADER.
- **HEADER**
  - `rx_ready`=1.
  - Collects 4 bytes, MSB first, into a 32-bit count N.
  - After the 4th byte:
    - N=0 → RUN (memory untouched).
    - 1 ≤ N ≤ DEPTH → LOAD, with word address 0 and byte index 0.
    - N > DEPTH → `load_error`=1, then IDLE.
- **LOAD**
  - `rx_ready`=1.
  - Assembles bytes MSB first: byte 0 → [31:24], byte 3 → [7:0].
  - On the edge accepting byte 3, writes the word to mem[addr] and increments addr.
  - When addr reaches N on that edge → RUN.
- **RUN**
  - `rx_ready`=0.
  - Serves fetches.
  - `load_req` → HEADER, with `cpu_reset` reasserted.
- A byte transfer occurs only on an edge where `rx_valid` && `rx_ready`.
- Bytes arriving while `rx_ready`=0 are ignored and not buffered. `rx_data` is don't-care when `rx_valid`=0.
- Gaps (`rx_valid` low) are allowed anywhere in a stream, with no timeout.
- `load_req` during HEADER or LOAD restarts at HEADER: byte index and addr are cleared, and words already written are kept.
- If `load_req` and a byte transfer coincide, `load_req` wins and the byte is dropped.
- Words at addresses ≥ N keep their previous contents. Memory is not cleared by `reset`; its contents are undefined after power-up.
- Fetch:
  - In RUN, each edge registers mem[`pc`[AW-1:0]].
  - If `pc` ≥ DEPTH (any upper bit set, or index ≥ DEPTH), the edge registers 0.
  - Outside RUN, `instruction` is registered as 0.

## Timing
- Reset values: state=IDLE, `instruction`=0, `rx_ready`=0, `cpu_reset`=1, `load_done`=0, `load_error`=0, byte index=0, addr=0.
- All outputs are registered or decoded from the state register. There is no combinational path from `rx_valid`, `pc` or `load_req` to any output.
- Loader throughput is 1 byte/clock. The minimum load time is 4 + 4N cycles of accepted bytes.
- `cpu_reset` falls and `load_done` rises in the cycle after the edge that writes the last word (or accepts the last header byte when N=0).
- Fetch latency is 1 cycle: `pc` sampled at edge k gives `instruction` valid after edge k.
- The first RUN edge may already return mem[`pc`]. A write and a fetch to the same address never overlap, because fetches occur only in RUN.
- `load_req` in RUN: at the next edge, state=HEADER, `cpu_reset`=1, `load_done`=0 and `instruction`=0, all on that same edge.
- Asynchronous `reset` mid-load abandons the load, returns to IDLE and leaves partially written memory as is.

## Test plan
- **Basic load.** Reset, `load_req`, then bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0.
  - `cpu_reset` falls 1 cycle after the 12th byte is accepted, and `load_done`=1.
  - `pc`=0 → 0x12345678 next cycle; `pc`=1 → 0x9ABCDEF0.
- **Stalls and backpressure.** Same stream with `rx_valid` toggled randomly.
  - Identical memory contents result.
  - `rx_valid` held high in IDLE and RUN never advances state.
- **Oversize header.** N=DEPTH+1 (0x00000041).
  - `load_error`=1, state returns to IDLE, `cpu_reset` stays 1.
  - A following `load_req` clears `load_error`.
- **Out-of-range fetch.** After a load, `pc`=DEPTH and `pc`=0x80000000 → `instruction`=0. `pc`=DEPTH-1 → the stored word.
- **Reload and abort.** In RUN, pulse `load_req`.
  - `cpu_reset`=1 next cycle.
  - Load N=1 with word 0xCAFEF00D → `pc`=0 returns 0xCAFEF00D, and `pc`=1 still returns the old 0x9ABCDEF0.
- **Async reset mid-load.** Assert `reset` between clock edges after 6 bytes.
  - All outputs reach reset values immediately.
  - No RUN is entered until a new `load_req` and a full stream.
